// File: rtl/assoc_score_seq.sv
// rtl/assoc_score_seq.sv - sequential associative-memory search with running argmax
//
// popcount16: 16-bit population count built as a balanced adder tree.
//   data_i   in  16  word to count
//   count_o  out 5   number of set bits, 0..16
//
// assoc_score_seq: streams the query and every class hypervector 16 bits per
// cycle, counts the AND-overlap per class and keeps the best (lowest index on
// ties) class.
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          search request (IDLE only) / synchronous cancel
//   rd_en, rd_class,      registered read strobe and (class, chunk) address;
//   rd_chunk              the address holds its value while rd_en is low
//   q_word, c_word        query / class words, valid one cycle after rd_en
//   busy, done            search in progress / one-cycle result pulse
//   best_class,           winning class and its overlap, held from done
//   best_score            until the next accepted start

module popcount16 (
    input  logic [15:0] data_i,
    output logic [4:0]  count_o
);

    logic [1:0] lvl1 [8];
    logic [2:0] lvl2 [4];
    logic [3:0] lvl3 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        count_o = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
    end

endmodule

module assoc_score_seq #(
    parameter int  DIM         = 1024,
    parameter int  NUM_CLASSES = 8,
    localparam int CHUNKS      = DIM / 16,
    localparam int ACC_W       = $clog2(DIM + 1),
    localparam int CLS_W       = $clog2(NUM_CLASSES),
    localparam int CHK_W       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             rd_en,
    output logic [CLS_W-1:0] rd_class,
    output logic [CHK_W-1:0] rd_chunk,
    input  logic [15:0]      q_word,
    input  logic [15:0]      c_word,
    output logic             busy,
    output logic             done,
    output logic [CLS_W-1:0] best_class,
    output logic [ACC_W-1:0] best_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             rd_en_q;
    logic [CLS_W-1:0] rd_class_q;
    logic [CHK_W-1:0] rd_chunk_q;
    logic             busy_q;
    logic             done_q;

    // Read-valid pipeline: the address of the read whose data arrives now.
    logic             vld_q;
    logic [CLS_W-1:0] tag_class_q;
    logic [CHK_W-1:0] tag_chunk_q;

    logic [ACC_W-1:0] acc_q;
    logic [CLS_W-1:0] best_class_q;
    logic [ACC_W-1:0] best_score_q;

    logic [15:0]      and_word;
    logic [4:0]       cnt;
    logic [ACC_W-1:0] sum_d;
    logic             tag_last;
    logic             issue_last;
    logic             chunk_last;

    assign and_word = q_word & c_word;

    popcount16 u_popcount (
        .data_i  (and_word),
        .count_o (cnt)
    );

    // ACC_W holds DIM, so the running sum never wraps.
    assign sum_d      = acc_q + ACC_W'(cnt);
    assign tag_last   = (tag_chunk_q == CHK_W'(CHUNKS - 1));
    assign chunk_last = (rd_chunk_q == CHK_W'(CHUNKS - 1));
    assign issue_last = chunk_last && (rd_class_q == CLS_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            rd_class_q   <= '0;
            rd_chunk_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vld_q        <= 1'b0;
            tag_class_q  <= '0;
            tag_chunk_q  <= '0;
            acc_q        <= '0;
            best_class_q <= '0;
            best_score_q <= '0;
        end else begin
            vld_q       <= rd_en_q;
            tag_class_q <= rd_class_q;
            tag_chunk_q <= rd_chunk_q;
            done_q      <= 1'b0;

            // Data path; the FSM below may override it on start or abort.
            if (vld_q) begin
                if (tag_last) begin
                    acc_q <= '0;
                    // Strict compare keeps the lowest class index on ties.
                    if (sum_d > best_score_q) begin
                        best_score_q <= sum_d;
                        best_class_q <= tag_class_q;
                    end
                end else begin
                    acc_q <= sum_d;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q      <= ISSUE;
                        rd_en_q      <= 1'b1;
                        rd_class_q   <= '0;
                        rd_chunk_q   <= '0;
                        busy_q       <= 1'b1;
                        acc_q        <= '0;
                        best_class_q <= '0;
                        best_score_q <= '0;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state_q      <= IDLE;
                        rd_en_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        vld_q        <= 1'b0;
                        acc_q        <= '0;
                        best_class_q <= '0;
                        best_score_q <= '0;
                    end else if (issue_last) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else if (chunk_last) begin
                        rd_chunk_q <= '0;
                        rd_class_q <= rd_class_q + CLS_W'(1);
                    end else begin
                        rd_chunk_q <= rd_chunk_q + CHK_W'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        // The final read's data is still in flight; drop it.
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        vld_q        <= 1'b0;
                        acc_q        <= '0;
                        best_class_q <= '0;
                        best_score_q <= '0;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_class   = rd_class_q;
    assign rd_chunk   = rd_chunk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_class = best_class_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_assoc_score_seq.sv
// tb/tb_assoc_score_seq.sv - scoreboard bench for assoc_score_seq

module tb_assoc_score_seq;

    localparam int DIM = 64;
    localparam int NC  = 4;
    localparam int CH  = 4;
    localparam int N   = NC * CH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [1:0]  rd_class;
    logic [1:0]  rd_chunk;
    logic [15:0] q_word = '0;
    logic [15:0] c_word = '0;
    logic        busy;
    logic        done;
    logic [1:0]  best_class;
    logic [6:0]  best_score;

    assoc_score_seq #(.DIM(DIM), .NUM_CLASSES(NC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_class   (rd_class),
        .rd_chunk   (rd_chunk),
        .q_word     (q_word),
        .c_word     (c_word),
        .busy       (busy),
        .done       (done),
        .best_class (best_class),
        .best_score (best_score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] qmem [CH];
    logic [15:0] cmem [NC][CH];

    // External memories: one cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            q_word <= qmem[rd_chunk];
            c_word <= cmem[rd_class][rd_chunk];
        end
    end

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    ev_t rd_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares DUT results and reads against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("best_class", int'(best_class), e.a);
                    check("best_score", int'(best_score), e.b);
                    check("busy_at_done", int'(busy), 0);
                end
            end
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got rd_en=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    ev_t r;
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r.cyc);
                    check("rd_class", int'(rd_class), r.a);
                    check("rd_chunk", int'(rd_chunk), r.b);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue an accepted start now; expected result and reads go to the scoreboard.
    task automatic start_search(input int cls, input int score);
        ev_t e;
        start = 1'b1;
        e.cyc = cyc + N + 2;
        e.a   = cls;
        e.b   = score;
        exp_q.push_back(e);
        for (int k = 0; k < N; k++) begin
            ev_t r;
            r.cyc = cyc + 1 + k;
            r.a   = k / CH;
            r.b   = k % CH;
            rd_q.push_back(r);
        end
        step(1);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_class"}, int'(rd_class), 0);
        check({tag, "_rd_chunk"}, int'(rd_chunk), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_best_class"}, int'(best_class), 0);
        check({tag, "_best_score"}, int'(best_score), 0);
    endtask

    task automatic set_query(input logic [15:0] w0, w1, w2, w3);
        qmem[0] = w0; qmem[1] = w1; qmem[2] = w2; qmem[3] = w3;
    endtask

    task automatic set_class(input int c, input logic [15:0] w0, w1, w2, w3);
        cmem[c][0] = w0; cmem[c][1] = w1; cmem[c][2] = w2; cmem[c][3] = w3;
    endtask

    task automatic load_distinct();
        set_query(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_class(0, 16'h03FF, 16'h0000, 16'h0000, 16'h0000); // 10
        set_class(1, 16'hFFFF, 16'hFFFF, 16'h001F, 16'h0000); // 37
        set_class(2, 16'hFFFF, 16'h003F, 16'h0000, 16'h0000); // 22
        set_class(3, 16'h0000, 16'h0000, 16'h0000, 16'h001F); // 5
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_result_pending"}, exp_q.size(), 0);
        check({tag, "_reads_pending"}, rd_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        step(3);
        rst_n = 1'b1;
        step(2);

        // Distinct overlaps, with the full read sequence checked
        load_distinct();
        start_search(1, 37);
        step(N + 2);
        check_drained("distinct");
        check("hold_class", int'(best_class), 1);
        check("hold_score", int'(best_score), 37);

        // Tie between classes 1 and 2
        set_class(0, 16'hFFFF, 16'h000F, 16'h0000, 16'h0000); // 20
        set_class(1, 16'hFFFF, 16'h3FFF, 16'h0000, 16'h0000); // 30
        set_class(2, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFF3); // 30
        set_class(3, 16'h0FFF, 16'h0000, 16'h0000, 16'h0000); // 12
        start_search(1, 30);
        step(N + 3);
        check_drained("tie");

        // Masked query: class 0 and 2 tie at 32, class 0 wins
        set_query(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        set_class(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); // 32
        set_class(1, 16'h5555, 16'h5555, 16'h5555, 16'h5555); // 0
        set_class(2, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA); // 32
        set_class(3, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0); // 16
        start_search(0, 32);
        step(N + 2);
        check_drained("mask");

        // All-zero memories
        set_query(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        for (int c = 0; c < NC; c++) set_class(c, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        start_search(0, 0);
        step(N + 2);
        check_drained("zero");

        // Maximum score in the last class
        set_query(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        set_class(3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        start_search(3, 64);
        step(N + 2);
        check_drained("max");

        // Reset mid-search at relative cycle 7
        load_distinct();
        start_search(1, 37);
        step(6);
        rst_n = 1'b0;
        exp_q.delete();
        rd_q.delete();
        #1;
        check_all_zero("midrst");
        step(2);
        rst_n = 1'b1;
        step(1);
        start_search(1, 37);
        step(N + 2);
        check_drained("after_rst");

        // Abort at relative cycle 9, restart at cycle 10
        start_search(1, 37);
        step(8);
        abort = 1'b1;
        begin
            int lim;
            lim = cyc;
            while (rd_q.size() > 0 && rd_q[$].cyc > lim) void'(rd_q.pop_back());
        end
        exp_q.delete();
        step(1);
        abort = 1'b0;
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_best_class", int'(best_class), 0);
        check("abort_best_score", int'(best_score), 0);
        start_search(1, 37);
        step(N + 2);
        check_drained("abort");

        // Starts while busy (cycle 5) and in DONE (cycle 18) are ignored
        set_class(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000); // 48
        start_search(0, 48);
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(12);
        check("ignored_done_now", int'(done), 1);
        start = 1'b1;
        step(1);
        load_distinct();
        start_search(1, 37);
        step(N + 2);
        check_drained("ignored");

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
